// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed driver for an N-digit common-anode
//               seven-segment display. Digit values, decimal-point flags and
//               a leading-zero-blank flag are captured on a load strobe into
//               a pending buffer and promoted to the active buffer only at a
//               frame boundary, so a displayed frame never tears. Each digit
//               slot lasts CLK_DIV cycles. The first GUARD cycles of a slot
//               keep everything dark, which stops the previous digit's
//               segments from ghosting onto the next one.
// Ports       : clk        - system clock
//               rst        - synchronous reset, active-high
//               numbers    - packed digit values, bits [4i+3:4i] = digit i
//               dp_mask    - decimal point enable per digit
//               blank_lz   - enable leading-zero blanking
//               load       - one-cycle capture strobe
//               seg        - segments h g f e d c b a (h = dp), 0 = lit
//               sel        - digit select, one-hot-low, 1 = off
//               frame_done - one-cycle pulse when the last slot ends
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 2,
    parameter int HEX_EN     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   numbers,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic                      blank_lz,
    input  logic                      load,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     sel,
    output logic                      frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      c_cnt_last = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]      c_guard    = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]      c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_sel_one  = NUM_DIGITS'(1);

    // Scan state
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_frame_done;

    // Pending (written by load) and active (displayed) buffers
    logic [4*NUM_DIGITS-1:0] r_pend_num;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_blz;
    logic                    r_pend_valid;
    logic [4*NUM_DIGITS-1:0] r_act_num;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic                    r_act_blz;

    // Registered outputs
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_sel;

    logic                    w_cnt_last;
    logic                    w_wrap;
    logic                    w_guard;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_cur_val;
    logic                    w_cur_dp;
    logic                    w_cur_blank;
    logic [7:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_sel_nxt;

    // Segment pattern gfedcba, active-low. Values 10-15 only reach this
    // function in the hex build; the decimal build overrides them later.
    function automatic logic [6:0] f_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            4'd10:   g = 7'b0001000;
            4'd11:   g = 7'b0000011;
            4'd12:   g = 7'b1000110;
            4'd13:   g = 7'b0100001;
            4'd14:   g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign w_cnt_last = (r_cnt == c_cnt_last);
    assign w_wrap     = w_cnt_last && (r_idx == c_idx_last);
    assign w_guard    = (r_cnt < c_guard);

    // Digit i (i>0) is blank when it and every digit above it are zero.
    // Walk from the top digit down, keeping a running "all zero so far".
    always_comb begin
        logic v_run;
        w_blank = '0;
        v_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run      = v_run & (r_act_num[4*i +: 4] == 4'd0);
            w_blank[i] = r_act_blz & v_run;
        end
    end

    // Pick the fields of the digit currently being scanned
    always_comb begin
        w_cur_val   = 4'd0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_val   = r_act_num[4*i +: 4];
                w_cur_dp    = r_act_dp[i];
                w_cur_blank = w_blank[i];
            end
        end
    end

    always_comb begin
        w_seg_nxt = 8'hFF;
        w_sel_nxt = '1;
        if (!w_guard) begin
            w_sel_nxt = ~(c_sel_one << r_idx);
            if (w_cur_blank) begin
                w_seg_nxt = {~w_cur_dp, 7'h7F};
            end else if ((HEX_EN == 0) && (w_cur_val >= 4'd10)) begin
                // Undefined glyph: every segment including dp lit
                w_seg_nxt = 8'h00;
            end else begin
                w_seg_nxt = {~w_cur_dp, f_glyph(w_cur_val)};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
            r_pend_num   <= '0;
            r_pend_dp    <= '0;
            r_pend_blz   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_act_num    <= '0;
            r_act_dp     <= '0;
            r_act_blz    <= 1'b0;
            r_seg        <= 8'hFF;
            r_sel        <= '1;
        end else begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);
            if (w_cnt_last) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
            end
            r_frame_done <= w_wrap;

            if (load) begin
                r_pend_num <= numbers;
                r_pend_dp  <= dp_mask;
                r_pend_blz <= blank_lz;
            end

            // Promotion uses the pre-edge pending content, so a load landing
            // on the wrap edge is kept for the following frame.
            if (w_wrap && r_pend_valid) begin
                r_act_num <= r_pend_num;
                r_act_dp  <= r_pend_dp;
                r_act_blz <= r_pend_blz;
            end

            if (load) begin
                r_pend_valid <= 1'b1;
            end else if (w_wrap) begin
                r_pend_valid <= 1'b0;
            end

            r_seg <= w_seg_nxt;
            r_sel <= w_sel_nxt;
        end
    end

    assign seg        = r_seg;
    assign sel        = r_sel;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
